// File: rtl/spi_flash_pkg.sv
// Shared definitions for the SPI flash master and its RDID capture stage.
//   id_state_e          - capture FSM state encoding
//   RDID_INSTRUCTION    - JEDEC read-ID opcode sent by the master
//   DEFAULT_EXPECTED_ID - {manufacturer, memory type, capacity} of the fitted part
//   id_byte()           - selects one byte of a 24-bit JEDEC ID (0 = manufacturer)
package spi_flash_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SKIP    = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_DONE    = 3'd3,
    ST_WAIT_CS = 3'd4
  } id_state_e;

  localparam logic [7:0]  RDID_INSTRUCTION    = 8'h9F;
  localparam logic [23:0] DEFAULT_EXPECTED_ID = 24'h20BA18;

  function automatic logic [7:0] id_byte(input logic [23:0] id, input logic [1:0] idx);
    logic [7:0] sel;
    case (idx)
      2'd0:    sel = id[23:16];
      2'd1:    sel = id[15:8];
      default: sel = id[7:0];
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/flash_id_capture_if.sv
// Bus between the SPI master side and the RDID capture stage.
//   spi_clk / spi_cs_n / spi_miso - registered SPI clock, chip select (active low), flash data out
//   manuf_id / mem_type / capacity - captured JEDEC ID bytes
//   id_valid / id_error            - one-cycle strobes (new ID, aborted frame)
//   id_match / busy                - levels (ID equals reference, capture in progress)
// master: drives the SPI lines and observes the results; slave: the capture stage.
interface flash_id_capture_if;
  logic       spi_clk;
  logic       spi_cs_n;
  logic       spi_miso;
  logic [7:0] manuf_id;
  logic [7:0] mem_type;
  logic [7:0] capacity;
  logic       id_valid;
  logic       id_match;
  logic       id_error;
  logic       busy;

  modport master (
    output spi_clk, spi_cs_n, spi_miso,
    input  manuf_id, mem_type, capacity, id_valid, id_match, id_error, busy
  );

  modport slave (
    input  spi_clk, spi_cs_n, spi_miso,
    output manuf_id, mem_type, capacity, id_valid, id_match, id_error, busy
  );
endinterface

// File: rtl/spi_edge_detect.sv
// Edge detector for the master's registered SPI clock and chip select.
//   clk, reset_n        - system clock, asynchronous active-low reset
//   spi_clk, spi_cs_n   - registered SPI clock / chip select (synchronous to clk)
//   sck_rise            - spi_clk is high now and was low last cycle
//   cs_fall / cs_rise   - chip select asserted / released this cycle
// The strobes are combinational against the one-cycle-delayed copies so that
// spi_miso is sampled in the same clk cycle the rising SPI edge appears.
module spi_edge_detect (
  input  logic clk,
  input  logic reset_n,
  input  logic spi_clk,
  input  logic spi_cs_n,
  output logic sck_rise,
  output logic cs_fall,
  output logic cs_rise
);

  logic sck_d_r;
  logic cs_d_r;

  // One-cycle delayed copies; chip select resets to its inactive (high) level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sck_d_r <= 1'b0;
      cs_d_r  <= 1'b1;
    end else begin
      sck_d_r <= spi_clk;
      cs_d_r  <= spi_cs_n;
    end
  end

  assign sck_rise = spi_clk & ~sck_d_r;
  assign cs_fall  = ~spi_cs_n & cs_d_r;
  assign cs_rise  = spi_cs_n & ~cs_d_r;

endmodule

// File: rtl/flash_id_capture.sv
// Receive side of the RDID transaction: ignores the instruction bits after CS
// falls, shifts in the 24 response bits MSB-first and presents the JEDEC ID.
//   clk, reset_n - system clock (also the SPI master's clock), async active-low reset
//   bus (slave)  - SPI inputs in; manuf_id/mem_type/capacity, id_valid, id_match,
//                  id_error, busy out (all registered)
module flash_id_capture
  import spi_flash_pkg::*;
#(
  parameter int          INST_BITS   = 8,
  parameter int          DATA_BITS   = 24,
  parameter logic [23:0] EXPECTED_ID = DEFAULT_EXPECTED_ID
) (
  input  logic               clk,
  input  logic               reset_n,
  flash_id_capture_if.slave  bus
);

  localparam logic [5:0] INST_LAST = 6'(INST_BITS) - 6'd1;
  localparam logic [5:0] DATA_LAST = 6'(DATA_BITS) - 6'd1;

  id_state_e   state_r, state_next_s;
  logic [5:0]  bit_cnt_r;
  logic [23:0] shift_r;
  logic        sck_rise_s, cs_fall_s, cs_rise_s;
  logic        cnt_clr_s, cnt_inc_s, shift_en_s, load_s, abort_s;

  logic [7:0]  manuf_id_r, mem_type_r, capacity_r;
  logic        id_valid_r, id_match_r, id_error_r, busy_r;

  spi_edge_detect u_edge (
    .clk      (clk),
    .reset_n  (reset_n),
    .spi_clk  (bus.spi_clk),
    .spi_cs_n (bus.spi_cs_n),
    .sck_rise (sck_rise_s),
    .cs_fall  (cs_fall_s),
    .cs_rise  (cs_rise_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state and datapath control. CS release is checked before the SPI
  // edge so a coincident edge is never counted on an aborted frame.
  always_comb begin
    state_next_s = state_r;
    cnt_clr_s    = 1'b0;
    cnt_inc_s    = 1'b0;
    shift_en_s   = 1'b0;
    load_s       = 1'b0;
    abort_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        cnt_clr_s = 1'b1;
        if (cs_fall_s) begin
          state_next_s = ST_SKIP;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_SKIP: begin
        if (cs_rise_s) begin
          abort_s      = 1'b1;
          cnt_clr_s    = 1'b1;
          state_next_s = ST_IDLE;
        end else if (sck_rise_s) begin
          if (bit_cnt_r == INST_LAST) begin
            cnt_clr_s    = 1'b1;
            state_next_s = ST_CAPTURE;
          end else begin
            cnt_inc_s = 1'b1;
          end
        end else begin
          state_next_s = ST_SKIP;
        end
      end
      ST_CAPTURE: begin
        if (cs_rise_s) begin
          abort_s      = 1'b1;
          cnt_clr_s    = 1'b1;
          state_next_s = ST_IDLE;
        end else if (sck_rise_s) begin
          shift_en_s = 1'b1;
          if (bit_cnt_r == DATA_LAST) begin
            cnt_clr_s    = 1'b1;
            state_next_s = ST_DONE;
          end else begin
            cnt_inc_s = 1'b1;
          end
        end else begin
          state_next_s = ST_CAPTURE;
        end
      end
      ST_DONE: begin
        load_s = 1'b1;
        // A CS release landing on this single cycle would otherwise be missed
        // and leave the block parked in WAIT_CS.
        if (cs_rise_s) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_WAIT_CS;
        end
      end
      ST_WAIT_CS: begin
        if (cs_rise_s) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_WAIT_CS;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Bit counter and response shift register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt_r <= 6'd0;
      shift_r   <= 24'd0;
    end else begin
      if (cnt_clr_s) begin
        bit_cnt_r <= 6'd0;
      end else if (cnt_inc_s) begin
        bit_cnt_r <= bit_cnt_r + 6'd1;
      end else begin
        bit_cnt_r <= bit_cnt_r;
      end
      if (shift_en_s) begin
        shift_r <= {shift_r[22:0], bus.spi_miso};
      end else begin
        shift_r <= shift_r;
      end
    end
  end

  // Output registers: ID bytes and match flag only move on the DONE cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      manuf_id_r <= 8'd0;
      mem_type_r <= 8'd0;
      capacity_r <= 8'd0;
      id_valid_r <= 1'b0;
      id_match_r <= 1'b0;
      id_error_r <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      if (load_s) begin
        manuf_id_r <= id_byte(shift_r, 2'd0);
        mem_type_r <= id_byte(shift_r, 2'd1);
        capacity_r <= id_byte(shift_r, 2'd2);
        id_match_r <= (shift_r == EXPECTED_ID);
      end else begin
        manuf_id_r <= manuf_id_r;
        mem_type_r <= mem_type_r;
        capacity_r <= capacity_r;
        id_match_r <= id_match_r;
      end
      id_valid_r <= load_s;
      id_error_r <= abort_s;
      busy_r     <= (state_next_s != ST_IDLE);
    end
  end

  assign bus.manuf_id = manuf_id_r;
  assign bus.mem_type = mem_type_r;
  assign bus.capacity = capacity_r;
  assign bus.id_valid = id_valid_r;
  assign bus.id_match = id_match_r;
  assign bus.id_error = id_error_r;
  assign bus.busy     = busy_r;

endmodule

// File: tb/tb_flash_id_capture.sv
// Directed, table-driven bench for flash_id_capture: whole RDID frames, an
// aborted frame, an over-long frame, reset mid-capture and a free-running clock.
module tb_flash_id_capture;
  import spi_flash_pkg::*;

  typedef struct {
    logic [23:0] id;
    int          n_edges;
    logic [7:0]  e_manuf;
    logic [7:0]  e_type;
    logic [7:0]  e_cap;
    logic        e_match;
    int          e_valid;
    int          e_err;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  flash_id_capture_if bus();

  flash_id_capture #(
    .INST_BITS   (8),
    .DATA_BITS   (24),
    .EXPECTED_ID (24'h20BA18)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int cyc = 0;
  int valid_cnt = 0;
  int err_cnt = 0;
  int busy_cnt = 0;
  int valid_cyc = 0;
  int rise32_cyc = 0;
  int n_chk = 0;
  int n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.id_valid) begin
      valid_cnt <= valid_cnt + 1;
      valid_cyc <= cyc;
    end
    if (bus.id_error) err_cnt <= err_cnt + 1;
    if (bus.busy) busy_cnt <= busy_cnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (act === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic send_bit(input logic b);
    @(posedge clk); #1;
    bus.spi_clk  = 1'b0;
    bus.spi_miso = b;
    @(posedge clk); #1;
    bus.spi_clk  = 1'b1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic [31:0] frame;
    int v0;
    int e0;
    frame = {RDID_INSTRUCTION, v.id};
    v0 = valid_cnt;
    e0 = err_cnt;
    @(posedge clk); #1;
    bus.spi_cs_n = 1'b0;
    bus.spi_clk  = 1'b0;
    for (int i = 0; i < v.n_edges; i++) begin
      if (i < 32) send_bit(frame[31-i]);
      else send_bit(i[0]);
      if (i == 31) rise32_cyc = cyc;
    end
    @(posedge clk); #1;
    bus.spi_clk = 1'b0;
    repeat (3) @(posedge clk);
    #1 bus.spi_cs_n = 1'b1;
    @(negedge clk);
    chk($sformatf("v%0d busy_before_cs_rise", idx), {31'd0, bus.busy}, 32'd1);
    @(negedge clk);
    chk($sformatf("v%0d busy_after_cs_rise", idx), {31'd0, bus.busy}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk($sformatf("v%0d manuf_id", idx), {24'd0, bus.manuf_id}, {24'd0, v.e_manuf});
    chk($sformatf("v%0d mem_type", idx), {24'd0, bus.mem_type}, {24'd0, v.e_type});
    chk($sformatf("v%0d capacity", idx), {24'd0, bus.capacity}, {24'd0, v.e_cap});
    chk($sformatf("v%0d id_match", idx), {31'd0, bus.id_match}, {31'd0, v.e_match});
    chk($sformatf("v%0d valid_pulses", idx), valid_cnt - v0, v.e_valid);
    chk($sformatf("v%0d error_pulses", idx), err_cnt - e0, v.e_err);
    if (v.e_valid > 0)
      chk($sformatf("v%0d valid_latency", idx), valid_cyc - rise32_cyc, 32'd2);
  endtask

  vec_t vecs[6];
  vec_t clean;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int v0;
    int e0;
    int b0;

    vecs[0] = '{24'h20BA18, 32, 8'h20, 8'hBA, 8'h18, 1'b1, 1, 0};
    vecs[1] = '{24'hEF4018, 32, 8'hEF, 8'h40, 8'h18, 1'b0, 1, 0};
    vecs[2] = '{24'h20BA18, 32, 8'h20, 8'hBA, 8'h18, 1'b1, 1, 0};
    vecs[3] = '{24'h123456, 20, 8'h20, 8'hBA, 8'h18, 1'b1, 0, 1};
    vecs[4] = '{24'hC22017, 40, 8'hC2, 8'h20, 8'h17, 1'b0, 1, 0};
    vecs[5] = '{24'h20BA18, 32, 8'h20, 8'hBA, 8'h18, 1'b1, 1, 0};
    clean   = '{24'h20BA18, 32, 8'h20, 8'hBA, 8'h18, 1'b1, 1, 0};

    // Reset state
    reset_n      = 1'b0;
    bus.spi_cs_n = 1'b1;
    bus.spi_clk  = 1'b0;
    bus.spi_miso = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst manuf_id", {24'd0, bus.manuf_id}, 32'd0);
    chk("rst mem_type", {24'd0, bus.mem_type}, 32'd0);
    chk("rst capacity", {24'd0, bus.capacity}, 32'd0);
    chk("rst id_valid", {31'd0, bus.id_valid}, 32'd0);
    chk("rst id_match", {31'd0, bus.id_match}, 32'd0);
    chk("rst id_error", {31'd0, bus.id_error}, 32'd0);
    chk("rst busy", {31'd0, bus.busy}, 32'd0);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);

    for (int k = 0; k < 6; k++) run_vec(vecs[k], k);

    // Reset in the middle of CAPTURE: outputs clear at once, no error pulse.
    e0 = err_cnt;
    @(posedge clk); #1;
    bus.spi_cs_n = 1'b0;
    for (int i = 0; i < 16; i++) send_bit(1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst manuf_id", {24'd0, bus.manuf_id}, 32'd0);
    chk("midrst mem_type", {24'd0, bus.mem_type}, 32'd0);
    chk("midrst capacity", {24'd0, bus.capacity}, 32'd0);
    chk("midrst id_match", {31'd0, bus.id_match}, 32'd0);
    chk("midrst busy", {31'd0, bus.busy}, 32'd0);
    bus.spi_cs_n = 1'b1;
    bus.spi_clk  = 1'b0;
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    repeat (2) @(posedge clk);
    chk("midrst error_pulses", err_cnt - e0, 32'd0);
    run_vec(clean, 6);

    // Free-running SPI clock with CS high must be ignored.
    v0 = valid_cnt;
    e0 = err_cnt;
    b0 = busy_cnt;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      bus.spi_clk  = ~bus.spi_clk;
      bus.spi_miso = i[1];
    end
    @(negedge clk);
    @(negedge clk);
    chk("freerun busy_cycles", busy_cnt - b0, 32'd0);
    chk("freerun valid_pulses", valid_cnt - v0, 32'd0);
    chk("freerun error_pulses", err_cnt - e0, 32'd0);
    chk("freerun manuf_id_held", {24'd0, bus.manuf_id}, 32'h20);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/flash_id_capture.md
# flash_id_capture

Receive-side stage for the RDID transaction of the SPI flash master. Monitors the master's registered SPI clock, active-low chip select and the flash MISO line. Skips the 8 instruction bits, shifts in the 24 response bits MSB-first, and presents manufacturer ID, memory type and capacity with a one-cycle valid strobe plus a compare against an expected ID. Sits directly downstream of the SPI master; its outputs feed the status/LED logic.

## Interface
- `INST_BITS`, 8: SPI clock rising edges ignored after CS falls (instruction phase).
- `DATA_BITS`, 24: response bits captured; fixed at 24 in this revision.
- `EXPECTED_ID`, 24'h20BA18: reference value for `id_match` ({manuf, type, capacity}).

- `clk`  in  1  system clock; same clock that generates `spi_clk`.
- `reset_n`  in  1  asynchronous, active-low reset.
- `spi_clk`  in  1  registered SPI clock from the master, synchronous to `clk`.
- `spi_cs_n`  in  1  registered chip select from the master, active low.
- `spi_miso`  in  1  flash serial data out, synchronous to `clk` at the board level.
- `manuf_id`  out  8  captured byte 0 (bits 23:16).
- `mem_type`  out  8  captured byte 1 (bits 15:8).
- `capacity`  out  8  captured byte 2 (bits 7:0).
- `id_valid`  out  1  one-cycle pulse: new ID latched on the outputs.
- `id_match`  out  1  level: last latched ID equals `EXPECTED_ID`.
- `id_error`  out  1  one-cycle pulse: CS deasserted before all 32 bits arrived.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- Edge detection: `sck_d` is `spi_clk` delayed one `clk`. `sck_rise = spi_clk & ~sck_d`. Mode 0 sampling: `spi_miso` is sampled in the `clk` cycle where `sck_rise` = 1.
- `cs_d` is `spi_cs_n` delayed one `clk`. `cs_fall = ~spi_cs_n & cs_d`. `cs_rise = spi_cs_n & ~cs_d`.
- 6-bit `bit_cnt` and 24-bit `shift_reg`.
- States:
  - IDLE: `bit_cnt` = 0. `cs_fall` → SKIP.
  - SKIP: each `sck_rise` increments `bit_cnt`. When `bit_cnt` reaches `INST_BITS` → CAPTURE, with `bit_cnt` cleared.
  - CAPTURE: each `sck_rise` does `shift_reg <= {shift_reg[22:0], spi_miso}` and increments `bit_cnt`. On the 24th edge → DONE.
  - DONE: lasts one cycle. Copies the final shift value to `manuf_id`/`mem_type`/`capacity`, pulses `id_valid` and updates `id_match`. → WAIT_CS.
  - WAIT_CS: further `sck_rise` edges are ignored. `cs_rise` → IDLE.
- Abort: `cs_rise` while in SKIP or CAPTURE pulses `id_error` for one cycle and returns to IDLE. The output bytes, `id_match` and `id_valid` are left unchanged.
- Simultaneous `cs_rise` and `sck_rise` in SKIP/CAPTURE: `cs_rise` wins, so the edge is not counted and the block aborts.
- `cs_fall` while in WAIT_CS or DONE is ignored; a new frame needs CS high for at least one cycle first.
- `spi_clk` toggling while CS is high (free-running master clock) has no effect.

## Timing
- Reset (`reset_n` low, asynchronous): state IDLE; `bit_cnt`, `shift_reg`, `sck_d` = 0; `cs_d` = 1. All outputs 0 (`manuf_id`, `mem_type`, `capacity`, `id_valid`, `id_match`, `id_error`, `busy`).
- Reset mid-frame: abandons capture immediately with no `id_error`. After release the block waits for the next `cs_fall`.
- `id_valid` asserts exactly 2 `clk` cycles after the `clk` edge on which the 32nd `spi_clk` rise is present on `spi_clk`: one cycle for edge detect and shift, one for the DONE register.
- `id_match` changes only in the same cycle as `id_valid` and holds until the next `id_valid` or reset.
- `busy` rises the cycle after `cs_fall` is detected and falls the cycle after `cs_rise` is detected.
- `id_error` is high for exactly one cycle per aborted frame.

## Structure
- Shared package `spi_flash_pkg`: state encoding (IDLE, SKIP, CAPTURE, DONE, WAIT_CS), `RDID_INSTRUCTION` = 8'h9F, default `EXPECTED_ID`. The SPI master also uses this package.
- Natural sub-module: `spi_edge_detect`, which registers `spi_clk`/`spi_cs_n` and produces `sck_rise`, `cs_fall` and `cs_rise`. Everything else stays in one module.

## Test plan
- Full frame, MISO drives 0x20, 0xBA, 0x18 after 8 don't-care bits → `id_valid` for 1 cycle; outputs 0x20/0xBA/0x18; `id_match` = 1; `id_error` = 0.
- Full frame with 0xEF, 0x40, 0x18 → outputs updated; `id_match` = 0.
- CS raised after 20 SPI edges, following a good frame → `id_error` pulses once; outputs and `id_match` keep their previous values; `busy` = 0 the cycle after.
- 40 SPI edges with CS low → a single `id_valid` after edge 32; edges 33–40 ignored; IDLE after CS rises.
- `reset_n` asserted mid-CAPTURE → all outputs 0 asynchronously. A following clean frame captures correctly.
- `spi_clk` free-running for 100 cycles with CS high → `busy`, `id_valid` and `id_error` stay 0.
